// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic {
    OwnerCpu = 1'b0,
    OwnerExt = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on contention the port that did not win last time is granted.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_grant,
  output logic [1:0] grant
);

  // Bit 0 is the CPU port, bit 1 the EXT port.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == OwnerExt) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU controller and an external loader/debug master,
// serialising req/ack transfers onto a valid/ready memory handshake with a response timeout.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    cpu_ack,
  output logic                    cpu_err,
  input  logic                    ext_req,
  input  logic                    ext_we,
  input  logic [ADDR_WIDTH-1:0]   ext_addr,
  input  logic [DATA_WIDTH-1:0]   ext_wdata,
  input  logic [DATA_WIDTH/8-1:0] ext_wstrb,
  output logic [DATA_WIDTH-1:0]   ext_rdata,
  output logic                    ext_ack,
  output logic                    ext_err,
  output logic                    mem_valid,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic                    grant_ext
);

  // A zero TIMEOUT still needs a legal one-bit counter even though it is never consulted.
  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                  state_q, state_d;
  owner_e                  owner_q, last_grant_q;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CntW-1:0]         cnt_q, cnt_d, cnt_inc;
  logic [1:0]              grant;
  logic                    grant_en, timeout_hit, in_resp;

  rr_arbiter2 u_rr_arbiter2 (
    .req        ({ext_req, cpu_req}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CntW'(TIMEOUT));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    grant_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (grant != 2'b00) begin
          grant_en = 1'b1;
          state_d  = StAccess;
        end
      end
      StAccess: begin
        // A ready arriving on the last permitted cycle still completes normally.
        if (mem_ready) begin
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_inc;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnerCpu;
      last_grant_q <= OwnerExt;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (grant_en) begin
        owner_q      <= grant[1] ? OwnerExt : OwnerCpu;
        last_grant_q <= grant[1] ? OwnerExt : OwnerCpu;
        we_q         <= grant[1] ? ext_we    : cpu_we;
        addr_q       <= grant[1] ? ext_addr  : cpu_addr;
        wdata_q      <= grant[1] ? ext_wdata : cpu_wdata;
        wstrb_q      <= grant[1] ? ext_wstrb : cpu_wstrb;
      end
    end
  end

  assign in_resp   = (state_q == StResp);
  assign mem_valid = (state_q == StAccess);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign grant_ext = (state_q != StIdle) && (owner_q == OwnerExt);

  assign cpu_ack   = in_resp && (owner_q == OwnerCpu);
  assign ext_ack   = in_resp && (owner_q == OwnerExt);
  assign cpu_err   = cpu_ack && err_q;
  assign ext_err   = ext_ack && err_q;
  assign cpu_rdata = cpu_ack ? rdata_q : '0;
  assign ext_rdata = ext_ack ? rdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an ack scoreboard and a simple memory responder.
module tb_mem_port_arbiter;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clock, reset;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [3:0]  cpu_wstrb, ext_wstrb;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        cpu_ack, cpu_err, ext_ack, ext_err;
  logic        mem_valid, mem_we, mem_ready, grant_ext;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int   total = 0;
  int   bad   = 0;
  int   ready_delay = 0;  // -1: memory never answers
  int   wait_cnt;
  exp_t sb[$];

  mem_port_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wstrb (cpu_wstrb),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_wstrb (ext_wstrb),
    .ext_rdata (ext_rdata),
    .ext_ack   (ext_ack),
    .ext_err   (ext_err),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .grant_ext (grant_ext)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset)                       wait_cnt <= 0;
    else if (mem_valid && !mem_ready) wait_cnt <= wait_cnt + 1;
    else                             wait_cnt <= 0;
  end
  assign mem_ready = mem_valid && (ready_delay >= 0) && (wait_cnt == ready_delay);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every ack is popped against the scoreboard; the idle port must stay silent.
  always @(negedge clock) begin
    if (!reset && (cpu_ack || ext_ack)) begin
      check("single_ack", {31'd0, cpu_ack && ext_ack}, 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_owner", {31'd0, ext_ack}, {31'd0, e.owner});
        check("ack_rdata", ext_ack ? ext_rdata : cpu_rdata, e.rdata);
        check("ack_err", {31'd0, ext_ack ? ext_err : cpu_err}, {31'd0, e.err});
        check("idle_rdata", ext_ack ? cpu_rdata : ext_rdata, 32'd0);
      end
    end
  end

  task automatic wait_ack(input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (cpu_ack || ext_ack) begin
        seen = 1'b1;
        break;
      end
    end
    check("ack_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic push(input logic owner, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.owner = owner;
    e.rdata = rdata;
    e.err   = err;
    sb.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0; ext_wstrb = 0;
    mem_rdata = 0;
    repeat (2) @(negedge clock);
    check("rst_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_ack", {30'd0, cpu_ack, ext_ack}, 32'd0);
    check("rst_grant_ext", {31'd0, grant_ext}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    reset = 1'b0;

    // CPU read, memory ready on first valid cycle
    @(negedge clock);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h100; ready_delay = 0; mem_rdata = 32'hDEADBEEF;
    push(1'b0, 32'hDEADBEEF, 1'b0);
    @(negedge clock);
    check("rd_valid", {31'd0, mem_valid}, 32'd1);
    check("rd_addr", mem_addr, 32'h100);
    check("rd_we", {31'd0, mem_we}, 32'd0);
    @(negedge clock);
    check("rd_latency_ack", {30'd0, cpu_ack, ext_ack}, 32'd2);
    cpu_req = 0;
    @(negedge clock);
    check("rd_idle", {31'd0, mem_valid}, 32'd0);

    // EXT write with three wait cycles
    ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_wdata = 32'h12345678; ext_wstrb = 4'hF;
    ready_delay = 3;
    push(1'b1, 32'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("wr_valid", {31'd0, mem_valid}, 32'd1);
      check("wr_fields", {mem_addr[7:0], mem_wstrb, 3'd0, mem_we},
            {8'h40, 4'hF, 3'd0, 1'b1});
      check("wr_wdata", mem_wdata, 32'h12345678);
      check("wr_grant_ext", {31'd0, grant_ext}, 32'd1);
      check("wr_no_ack", {30'd0, cpu_ack, ext_ack}, 32'd0);
    end
    @(negedge clock);
    check("wr_ack", {30'd0, cpu_ack, ext_ack}, 32'd1);
    ext_req = 0;
    @(negedge clock);

    // Round-robin from reset with both requesting continuously
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    ready_delay = 0; mem_rdata = 32'h11112222;
    cpu_we = 0; ext_we = 0; cpu_addr = 32'h200; ext_addr = 32'h300;
    cpu_req = 1; ext_req = 1;
    push(1'b0, 32'h11112222, 1'b0);
    push(1'b1, 32'h11112222, 1'b0);
    push(1'b0, 32'h11112222, 1'b0);
    push(1'b1, 32'h11112222, 1'b0);
    for (int i = 0; i < 4; i++) wait_ack(6);
    cpu_req = 0; ext_req = 0;
    @(negedge clock);

    // Timeout: memory never ready
    ready_delay = -1; mem_rdata = 32'hBAD0BAD0;
    cpu_req = 1; cpu_addr = 32'h500;
    push(1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("to_valid", {31'd0, mem_valid}, 32'd1);
    end
    @(negedge clock);
    check("to_valid_drop", {31'd0, mem_valid}, 32'd0);
    check("to_ack_err", {30'd0, cpu_ack, cpu_err}, 32'd3);
    cpu_req = 0;
    @(negedge clock);
    ready_delay = 0; mem_rdata = 32'hCAFEF00D; cpu_req = 1; cpu_addr = 32'h104;
    push(1'b0, 32'hCAFEF00D, 1'b0);
    wait_ack(5);
    cpu_req = 0;
    @(negedge clock);

    // Reset mid-access abandons the transfer; CPU then wins contention
    ready_delay = -1; cpu_req = 1; cpu_addr = 32'h600;
    @(negedge clock);
    check("rm_valid", {31'd0, mem_valid}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rm_valid_drop", {31'd0, mem_valid}, 32'd0);
    check("rm_no_ack", {30'd0, cpu_ack, ext_ack}, 32'd0);
    ext_req = 1; ext_addr = 32'h700; ext_we = 0;
    @(negedge clock);
    reset = 1'b0; ready_delay = 0; mem_rdata = 32'h5555AAAA;
    push(1'b0, 32'h5555AAAA, 1'b0);
    push(1'b1, 32'h5555AAAA, 1'b0);
    @(negedge clock);
    check("rm_first_grant", {mem_valid, grant_ext}, {1'b1, 1'b0});
    wait_ack(4);
    cpu_req = 0;
    wait_ack(5);
    ext_req = 0;
    @(negedge clock);

    // CPU write; request fields change while the access waits
    ready_delay = 2; cpu_req = 1; cpu_we = 1; cpu_addr = 32'h80;
    cpu_wdata = 32'hA1B2C3D4; cpu_wstrb = 4'h3;
    push(1'b0, 32'd0, 1'b0);
    @(negedge clock);
    cpu_addr = 32'hFFC; cpu_wdata = 32'h0; cpu_wstrb = 4'hC;
    for (int i = 0; i < 3; i++) begin
      check("hold_addr", mem_addr, 32'h80);
      check("hold_data", mem_wdata, 32'hA1B2C3D4);
      check("hold_strb", {28'd0, mem_wstrb}, 32'h3);
      if (i < 2) @(negedge clock);
    end
    wait_ack(3);
    cpu_req = 0;
    repeat (2) @(negedge clock);

    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between two requesters:
- the core's multicycle controller (CPU port: instruction fetch and load/store);
- an external loader/debug master (EXT port: program load and memory inspection).

Each port uses a req/ack handshake. Transfers are serialised to memory through a valid/ready handshake, with round-robin arbitration and a response timeout. The block sits between the core datapath address mux and the memory.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; byte strobe width is DATA_WIDTH/8
TIMEOUT, 255, maximum cycles mem_valid may wait for mem_ready; 0 disables the timeout

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cpu_req  in  1  CPU request; held with its fields until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_WIDTH  byte address
cpu_wdata  in  DATA_WIDTH  write data
cpu_wstrb  in  DATA_WIDTH/8  byte enables (writes only)
cpu_rdata  out  DATA_WIDTH  read data, valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  qualifies cpu_ack; 1 = timeout
ext_req, ext_we, ext_addr, ext_wdata, ext_wstrb, ext_rdata, ext_ack, ext_err: same directions, widths and meanings as the cpu_* ports
mem_valid  out  1  memory request valid
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_wstrb  out  DATA_WIDTH/8  memory byte enables
mem_rdata  in  DATA_WIDTH  memory read data, sampled when mem_valid && mem_ready
mem_ready  in  1  memory accepts and completes the access this cycle
grant_ext  out  1  1 while EXT owns the port (status)

Behaviour:
- Reset (asynchronous):
  - state = IDLE; last_grant = EXT, so the CPU wins the first contention.
  - All outputs 0: mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, *_ack, *_err, *_rdata, grant_ext.
  - A memory access in flight is abandoned; no ack is issued for it.
- State machine: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not equal to last_grant.
  - At the grant edge, latch owner, we, addr, wdata and wstrb into registers, and update last_grant.
  - Go to ACCESS; with no req, stay in IDLE.
- ACCESS:
  - mem_valid = 1. The mem_* outputs are driven from the latched registers and stay stable until mem_ready.
  - When mem_ready = 1: capture mem_rdata (reads only; writes return 0), err = 0, go to RESP.
  - When TIMEOUT != 0 and the wait counter reaches TIMEOUT without mem_ready: err = 1, rdata = 0, go to RESP. mem_valid drops on that edge.
  - The wait counter clears on entry to ACCESS. Its width is clog2(TIMEOUT+1), and it never wraps.
- RESP:
  - The owner's ack = 1 for exactly one cycle, with registered rdata/err. The other port's ack, err and rdata stay 0.
  - Always go to IDLE.
- Latency: req sampled in IDLE at cycle n -> mem_valid at n+1 -> if mem_ready at n+1, ack at n+2.
  - Minimum is 3 cycles per transfer, including the IDLE turnaround.
- Requester rules:
  - A requester drops req, or presents a new request, in the cycle after ack.
  - A req still high in IDLE is treated as a new request.
  - Changes to request fields while waiting are ignored, because the fields were latched at grant.
- A request arriving during ACCESS/RESP waits; there is no preemption. grant_ext reflects the latched owner during ACCESS and RESP, and is 0 in IDLE.
- Simultaneous requests under round-robin: two ports requesting continuously alternate grants, so each is served at least every second transfer.
- A mem_ready seen outside ACCESS is ignored.

Decomposition:
- Shared package: state encoding (IDLE, ACCESS, RESP) and owner encoding (OWNER_CPU = 0, OWNER_EXT = 1).
- Natural sub-module: rr_arbiter2. It is combinational two-way round-robin pick logic from req[1:0] and last_grant, and returns a grant one-hot.

Test Plan:
- CPU read, addr 0x100, mem_ready on the first valid cycle, mem_rdata 0xDEADBEEF -> cpu_ack at cycle 2 with cpu_rdata 0xDEADBEEF, cpu_err 0; ext_ack stays 0.
- EXT write, addr 0x40, wdata 0x12345678, wstrb 0xF, mem_ready delayed 3 cycles -> mem_valid held 4 cycles with stable fields, then ext_ack; total 5 cycles.
- Both req high continuously from reset, 4 transfers -> grant order CPU, EXT, CPU, EXT.
- TIMEOUT=4, mem_ready never asserted -> mem_valid high 4 cycles, then cpu_ack with cpu_err = 1 and cpu_rdata = 0; next request is served normally.
- Reset asserted mid-ACCESS -> mem_valid drops immediately, no ack. After release, a pending CPU req is granted with last_grant = EXT.
- cpu_addr changed during ACCESS -> mem_addr keeps the address latched at grant.
